// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, oversample default and baud divisor helper shared by the UART blocks.
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

   localparam int OVERSAMPLE_DEF = 16;

   // Clocks per sample tick, rounded to nearest and never below 1.
   function automatic int calc_div(input int clk_freq, input int baud, input int os);
      int d;
      d = (clk_freq + (baud * os) / 2) / (baud * os);
      return (d < 1) ? 1 : d;
   endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-clk sample tick every DIV clocks; clr realigns the phase.
module uart_baud_tick #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);
   localparam int W = $clog2(DIV) + 1;
   localparam logic [W-1:0] TOP = W'(DIV - 1);

   logic [W-1:0] cnt;

   assign tick = cnt == TOP;

   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: oversampling 8N1 UART receiver with glitch-start rejection and framing check.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_done,
   output logic       frame_err,
   output logic       parity_err,
   output logic       rx_busy
);
   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] MID = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);
`ifdef UART_RX_PARITY_EN
   localparam uart_state_t AFTER_DATA = PARITY;
`else
   localparam uart_state_t AFTER_DATA = STOP;
`endif

   uart_state_t state;
   logic rxd_m, rxd_s, armed, tick, clr;
   logic [SW-1:0] scnt;
   logic [2:0] idx;
   logic [7:0] shift;

   assign clr = state == IDLE && armed && !rxd_s;
   assign rx_busy = state != IDLE;

   uart_baud_tick #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .clr(clr), .tick(tick));

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

   // armed drops after an error so a held-low line must return high before the next start.
   always_ff @(posedge clk)
      if (rst) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
         armed <= 1'b0;
         state <= IDLE;
         scnt <= '0;
         idx <= '0;
         shift <= '0;
         rx_data <= '0;
         rx_done <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         rxd_m <= rxd;
         rxd_s <= rxd_m;
         rx_done <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         case (state)
            IDLE:
               if (!armed) armed <= rxd_s;
               else if (!rxd_s) begin
                  state <= START;
                  scnt <= '0;
               end
            START:
               if (tick) begin
                  scnt <= scnt + 1'b1;
                  if (scnt == MID) begin
                     scnt <= '0;
                     idx <= '0;
                     state <= rxd_s ? IDLE : DATA;
                  end
               end
            DATA:
               if (tick) begin
                  scnt <= scnt + 1'b1;
                  if (scnt == LAST) begin
                     shift <= {rxd_s, shift[7:1]};
                     idx <= idx + 1'b1;
                     if (idx == 3'd7) state <= AFTER_DATA;
                  end
               end
`ifdef UART_RX_PARITY_EN
            PARITY:
               if (tick) begin
                  scnt <= scnt + 1'b1;
                  if (scnt == LAST) begin
                     if (^shift ^ rxd_s) begin
                        parity_err <= 1'b1;
                        armed <= 1'b0;
                        state <= IDLE;
                     end else state <= STOP;
                  end
               end
`endif
            STOP:
               if (tick) begin
                  scnt <= scnt + 1'b1;
                  if (scnt == LAST) begin
                     if (rxd_s) begin
                        rx_data <= shift;
                        rx_done <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                        armed <= 1'b0;
                     end
                     state <= IDLE;
                  end
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed frames at DIV=10, 16x oversample (160 clk per bit).
// Define UART_RX_PARITY_EN to exercise the even-parity build.
module tb_uart_rx_byte;
   localparam int BIT = 160;
`ifdef UART_RX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int LAT = (2 * FB - 1) * BIT / 2;

   logic clk = 1'b0, rst = 1'b1, rxd = 1'b1;
   logic [7:0] rx_data;
   logic rx_done, frame_err, parity_err, rx_busy;
   int checks = 0, errors = 0;
   int cyc = 0, n_done = 0, n_ferr = 0, n_perr = 0, n_multi = 0, t_done = 0, t_prev = 0;
   logic [7:0] d_last = '0, d_prev = '0;

   uart_rx_byte #(.CLK_FREQ(18432000), .BAUD(115200), .OVERSAMPLE(16)) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .rx_data(rx_data), .rx_done(rx_done),
      .frame_err(frame_err), .parity_err(parity_err), .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (rx_done) begin
         n_done <= n_done + 1;
         t_prev <= t_done;
         t_done <= cyc;
         d_prev <= d_last;
         d_last <= rx_data;
      end
      if (frame_err) n_ferr <= n_ferr + 1;
      if (parity_err) n_perr <= n_perr + 1;
      if (int'(rx_done) + int'(frame_err) + int'(parity_err) > 1) n_multi <= n_multi + 1;
   end

   task automatic drive_bit(input logic b);
      rxd = b;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) drive_bit(1'b1);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(par);
`endif
      drive_bit(stop);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({rx_data, rx_done, frame_err, parity_err, rx_busy} !== 12'h000) begin
         errors++;
         $display("FAIL reset_outputs got %h required 000", {rx_data, rx_done, frame_err, parity_err, rx_busy});
      end
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_basic;
      int d0 = n_done, f0 = n_ferr, t0;
      t0 = cyc;
      send_frame(8'hA5, 1'b0, 1'b1);
      idle(1);
      checks++;
      if (n_done - d0 !== 1) begin errors++; $display("FAIL basic_done_count got %0d required 1", n_done - d0); end
      checks++;
      if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h required a5", rx_data); end
      checks++;
      if (n_ferr != f0) begin errors++; $display("FAIL basic_frame_err got %0d required 0", n_ferr - f0); end
      checks++;
      if (rx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b required 0", rx_busy); end
      checks++;
      if (t_done - t0 < LAT || t_done - t0 > LAT + 5) begin
         errors++;
         $display("FAIL basic_latency got %0d required %0d..%0d", t_done - t0, LAT, LAT + 5);
      end
   endtask

   task automatic test_glitch;
      int d0 = n_done, f0 = n_ferr, t0, k;
      t0 = cyc;
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      rxd = 1'b1;
      checks++;
      if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise got %b required 1", rx_busy); end
      for (k = 0; k < 200 && rx_busy; k++) @(negedge clk);
      checks++;
      if (rx_busy) begin
         errors++;
         $display("FAIL glitch_busy_timeout got busy after 200 clk required idle");
      end else if (cyc - t0 < 80 || cyc - t0 > 86) begin
         errors++;
         $display("FAIL glitch_busy_fall got %0d required 80..86", cyc - t0);
      end
      idle(2);
      checks++;
      if (n_done != d0 || n_ferr != f0) begin
         errors++;
         $display("FAIL glitch_pulses got done %0d ferr %0d required 0 0", n_done - d0, n_ferr - f0);
      end
   endtask

   task automatic test_frame_err;
      int d0 = n_done, f0 = n_ferr;
      send_frame(8'h3C, 1'b0, 1'b0);
      idle(2);
      checks++;
      if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_count got %0d required 1", n_ferr - f0); end
      checks++;
      if (n_done != d0) begin errors++; $display("FAIL ferr_done got %0d required 0", n_done - d0); end
      checks++;
      if (rx_data !== 8'hA5) begin errors++; $display("FAIL ferr_data_held got %h required a5", rx_data); end
   endtask

   task automatic test_back_to_back;
      int d0 = n_done;
      send_frame(8'h12, 1'b0, 1'b1);
      send_frame(8'h34, 1'b1, 1'b1);
      idle(2);
      checks++;
      if (n_done - d0 !== 2) begin errors++; $display("FAIL b2b_done_count got %0d required 2", n_done - d0); end
      checks++;
      if (d_prev !== 8'h12 || d_last !== 8'h34) begin
         errors++;
         $display("FAIL b2b_data got %h %h required 12 34", d_prev, d_last);
      end
      checks++;
      if (t_done - t_prev !== FB * BIT) begin
         errors++;
         $display("FAIL b2b_spacing got %0d required %0d", t_done - t_prev, FB * BIT);
      end
   endtask

   task automatic test_reset_mid;
      int d0 = n_done, f0 = n_ferr;
      drive_bit(1'b0);
      repeat (4) drive_bit(1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (rx_data !== 8'h00 || rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_state got data %h busy %b required 00 0", rx_data, rx_busy);
      end
      idle(6);
      checks++;
      if (n_done != d0 || n_ferr != f0) begin
         errors++;
         $display("FAIL rstmid_pulses got done %0d ferr %0d required 0 0", n_done - d0, n_ferr - f0);
      end
      send_frame(8'h5A, 1'b0, 1'b1);
      idle(1);
      checks++;
      if (n_done - d0 !== 1 || rx_data !== 8'h5A) begin
         errors++;
         $display("FAIL rstmid_next got done %0d data %h required 1 5a", n_done - d0, rx_data);
      end
   endtask

   task automatic test_parity;
      int d0 = n_done, p0 = n_perr;
`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b0, 1'b1);
      idle(1);
      checks++;
      if (n_perr - p0 !== 1 || n_done != d0 || rx_data !== 8'h5A) begin
         errors++;
         $display("FAIL parity_bad got perr %0d done %0d data %h required 1 0 5a", n_perr - p0, n_done - d0, rx_data);
      end
      send_frame(8'h07, 1'b1, 1'b1);
      idle(1);
      checks++;
      if (n_perr - p0 !== 1 || n_done - d0 !== 1 || rx_data !== 8'h07) begin
         errors++;
         $display("FAIL parity_good got perr %0d done %0d data %h required 1 1 07", n_perr - p0, n_done - d0, rx_data);
      end
`else
      checks++;
      if (n_perr != 0 || parity_err !== 1'b0) begin
         errors++;
         $display("FAIL parity_tied got %0d pulses required 0", n_perr);
      end
`endif
      checks++;
      if (n_multi != 0) begin errors++; $display("FAIL pulse_exclusive got %0d overlaps required 0", n_multi); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_glitch;
      test_frame_err;
      test_back_to_back;
      test_reset_mid;
      test_parity;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
UART receiver feeding the FIR wrapper's byte-assembly registers. Oversamples the asynchronous rxd line and recovers 8N1 frames, LSB first. Presents each good byte on rx_data with a one-cycle rx_done pulse, which the wrapper consumes directly. Flags framing errors and rejects glitch start bits.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line baud rate
OVERSAMPLE, 16, sample ticks per bit; power of two, minimum 8
DIV, CLK_FREQ/(BAUD*OVERSAMPLE), clocks per sample tick; derived, rounded to nearest, minimum 1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rxd  in  1  asynchronous serial input; idle high
rx_data  out  8  last good received byte; held until the next good byte
rx_done  out  1  one-cycle pulse, rx_data valid in the same cycle
frame_err  out  1  one-cycle pulse, stop bit sampled low
parity_err  out  1  one-cycle pulse on parity mismatch; tied 0 when parity is compiled out
rx_busy  out  1  high while not in IDLE

Behaviour:
- Interface: clock clk; reset rst, synchronous, active-high.
- Reset values:
  - rx_data = 8'h00; rx_done, frame_err, parity_err, rx_busy = 0.
  - Synchroniser flops = 1; state = IDLE; all counters = 0.
- Synchroniser: rxd passes through two flops (rxd_s); all decisions use rxd_s only.
- Tick generator: a counter 0..DIV-1 asserts tick for one clk on the wrap. It is cleared on IDLE->START, so the phase is aligned to the start edge.
- Per-state sample counter scnt, 0..OVERSAMPLE-1, advances on each tick.
- IDLE: rxd_s==0 -> START, clearing the tick counter and scnt.
- START: at scnt==OVERSAMPLE/2-1 (mid start bit), sample rxd_s.
  - rxd_s==1: false start -> IDLE, no pulse.
  - rxd_s==0: -> DATA, with scnt=0 and bit index=0.
- DATA: every OVERSAMPLE ticks (mid bit), shift rxd_s into bit[idx] (LSB first).
  - After idx==7 -> STOP (or PARITY when the parity feature is compiled in).
- STOP: at mid stop bit, sample rxd_s.
  - 1: rx_data <= shift register; rx_done=1 for exactly one clk.
  - 0: frame_err=1 for one clk; rx_data unchanged.
  - Both cases return to IDLE on the same cycle. The receiver is re-armed at mid stop bit, so back-to-back frames are received without a gap.
- Latency: rx_done rises 9.5 bit periods + 2..3 clk after the rxd falling edge.
- rx_done, frame_err and parity_err are mutually exclusive; at most one pulse per frame.
- Break (line held low): frame_err once, then IDLE. IDLE waits for rxd_s==1 before arming again, so a held-low line does not produce repeated frames.
- Reset mid-frame: immediate abandon; no pulse; the next frame is received normally.
- Width rules: scnt is $clog2(OVERSAMPLE) bits; idx is 3 bits; the tick counter is $clog2(DIV)+1 bits.

Optional Feature:
UART_RX_PARITY_EN:
- Defined:
  - A PARITY state follows DATA and samples one extra bit at mid bit.
  - Even parity: the XOR of the 8 data bits and the parity bit must be 0.
  - Mismatch: parity_err pulse, then IDLE. No rx_done; rx_data is held.
  - Match: -> STOP, which behaves as above.
- Undefined: 8N1 frames only; parity_err constant 0; no PARITY state.

Decomposition:
- Package uart_pkg:
  - State encoding (IDLE, START, DATA, PARITY, STOP).
  - OVERSAMPLE default.
  - Constant function calc_div(clk_freq, baud, os).
  - Shared by the future uart_tx_byte.
- Sub-module uart_baud_tick(clk, rst, clr, tick), parameter DIV. Reused by the transmitter.

Test Plan:
Bench parameters for all tests: CLK_FREQ=18432000, BAUD=115200, OVERSAMPLE=16, so DIV=10 and one bit = 160 clk.
1. Send 0xA5 (8N1) -> rx_data=8'hA5 with a single-cycle rx_done about 1520 clk after the start edge; frame_err=0; rx_busy back to 0.
2. Drive rxd low for 4 clk, then high -> no rx_done or frame_err; rx_busy falls about 80 clk after the edge.
3. Send 0x3C with the stop bit forced 0, after a prior good 0xA5 -> one frame_err pulse, no rx_done, rx_data stays 8'hA5.
4. Send 0x12 and 0x34 back-to-back, zero idle bits -> two rx_done pulses carrying 8'h12 then 8'h34, spaced 1600 clk apart.
5. Assert rst for 1 clk after the 4th data bit of 0xFF, then send 0x5A -> no pulse for the aborted frame; rx_data=8'h00 after reset, then 8'h5A with one rx_done.
6. With UART_RX_PARITY_EN defined, send 0x07 + parity bit 0 -> parity_err pulse, no rx_done; resend 0x07 + parity bit 1 -> rx_done with 8'h07.
